extender_stage: RTL and testbench

EXTENDER_STAGE -- requirements
Module: extender_stage

---
 rtl/extender_stage.sv | 130 +++++++++++++
 tb/tb_extender_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/extender_stage.sv
// Immediate extender (sign/zero/upper/branch-offset) behind a registered valid/ready output stage.
// Define EXTENDER_STAGE_SKID_EN for a 2-entry skid buffer with registered inReady; default is a single output register.
module extender_stage #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int BR_SHIFT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [IN_WIDTH-1:0]  dataIn,
  input  logic [1:0]           modeIn,
  input  logic                 flush,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [OUT_WIDTH-1:0] dataOut
);

  localparam int E = OUT_WIDTH - IN_WIDTH;

  logic [OUT_WIDTH-1:0] sext_dat;
  logic [OUT_WIDTH-1:0] ext_dat;

  assign sext_dat = {{E{dataIn[IN_WIDTH-1]}}, dataIn};

  always_comb begin
    ext_dat = '0;
    case (modeIn)
      2'b00:   ext_dat = sext_dat;
      2'b01:   ext_dat = {{E{1'b0}}, dataIn};
      2'b10:   ext_dat = {dataIn, {E{1'b0}}};
      default: ext_dat = sext_dat << BR_SHIFT;
    endcase
  end

`ifdef EXTENDER_STAGE_SKID_EN

  logic                 head_vld, head_vld_n;
  logic                 tail_vld, tail_vld_n;
  logic [OUT_WIDTH-1:0] head_dat, head_dat_n;
  logic [OUT_WIDTH-1:0] tail_dat, tail_dat_n;
  logic                 rdy_q, rdy_n;
  logic                 acc, pop;

  // rdy_q depends only on occupancy, so outReady never reaches inReady combinationally.
  assign inReady  = rdy_q && !flush;
  assign outValid = head_vld;
  assign dataOut  = head_vld ? head_dat : '0;
  assign acc      = inValid && inReady;
  assign pop      = head_vld && outReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
      head_dat <= '0;
      tail_dat <= '0;
      rdy_q    <= 1'b1;
    end else begin
      head_vld <= head_vld_n;
      tail_vld <= tail_vld_n;
      head_dat <= head_dat_n;
      tail_dat <= tail_dat_n;
      rdy_q    <= rdy_n;
    end
  end

  always_comb begin
    head_vld_n = head_vld;
    tail_vld_n = tail_vld;
    head_dat_n = head_dat;
    tail_dat_n = tail_dat;
    if (flush) begin
      head_vld_n = 1'b0;
      tail_vld_n = 1'b0;
      head_dat_n = '0;
      tail_dat_n = '0;
    end else if (!head_vld) begin
      if (acc) begin
        head_vld_n = 1'b1;
        head_dat_n = ext_dat;
      end
    end else if (!tail_vld) begin
      if (pop && acc) begin
        head_dat_n = ext_dat;
      end else if (pop) begin
        head_vld_n = 1'b0;
        head_dat_n = '0;
      end else if (acc) begin
        tail_vld_n = 1'b1;
        tail_dat_n = ext_dat;
      end
    end else if (pop) begin
      // Full: tail slides into head; nothing can be accepted this cycle.
      head_dat_n = tail_dat;
      tail_vld_n = 1'b0;
      tail_dat_n = '0;
    end
    rdy_n = !(head_vld_n && tail_vld_n);
  end

`else

  logic                 vld_q;
  logic [OUT_WIDTH-1:0] dat_q;

  assign inReady  = !flush && (!vld_q || outReady);
  assign outValid = vld_q;
  assign dataOut  = vld_q ? dat_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (inValid && inReady) begin
      vld_q <= 1'b1;
      dat_q <= ext_dat;
    end else if (vld_q && outReady) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_extender_stage.sv
// Directed bench for extender_stage: scoreboard fed at acceptance, monitor checks each transfer.
module tb_extender_stage;

`ifdef EXTENDER_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [15:0] dataIn;
  logic [1:0]  modeIn;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [31:0] dataOut;

  logic [31:0] cur_exp;
  logic [31:0] sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          accepts = 0;
  int          pops = 0;
  int          cyc = 0;

  extender_stage #(.IN_WIDTH(16), .OUT_WIDTH(32), .BR_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .dataIn(dataIn), .modeIn(modeIn), .flush(flush), .outValid(outValid),
    .outReady(outReady), .dataOut(dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: decides handshakes mid-cycle, which hold until the next rising edge.
  always @(negedge clk) begin
    if (reset || flush) begin
      sbq.delete();
    end else begin
      if (outValid && outReady) begin
        pops++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected output: got %h with empty scoreboard", dataOut);
        end else begin
          check("dataOut order", dataOut, sbq.pop_front());
        end
      end
      if (!outValid) check("dataOut idle zero", dataOut, 32'h0);
      if (inValid && inReady) begin
        sbq.push_back(cur_exp);
        accepts++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [15:0] d, input logic [31:0] e);
    inValid = 1'b1;
    modeIn  = m;
    dataIn  = d;
    cur_exp = e;
  endtask

  // Offers one request until accepted (bounded), returning at posedge+1.
  task automatic send(input logic [1:0] m, input logic [15:0] d, input logic [31:0] e);
    logic ok;
    logic done;
    done = 1'b0;
    drive(m, d, e);
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      ok = inReady;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send timeout: got inReady=0 expected acceptance of %h", d);
    end
    inValid = 1'b0;
  endtask

  logic [1:0]  s_mode[8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01};
  logic [15:0] s_data[8] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h0001, 16'h0001, 16'h8000, 16'hABCD, 16'h7FFF};
  logic [31:0] s_exp[8]  = '{32'h00000001, 32'hFFFFFFFF, 32'h00008000, 32'h00010000,
                             32'h00000004, 32'hFFFE0000, 32'hABCD0000, 32'h00007FFF};
  logic [1:0]  b_mode[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [15:0] b_data[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h0444};
  logic [31:0] b_exp[4]  = '{32'h00001111, 32'h00002222, 32'h33330000, 32'h00001110};

  initial begin
    int c0;
    int p0;
    int a0;
    reset = 1'b1; inValid = 1'b0; dataIn = '0; modeIn = '0; flush = 1'b0;
    outReady = 1'b0; cur_exp = '0;
    #3;
    check("reset outValid", {31'b0, outValid}, 32'h0);
    check("reset dataOut", dataOut, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("inReady after reset", {31'b0, inReady}, 32'h1);

    // Single request, latency one cycle.
    outReady = 1'b1;
    send(2'b00, 16'h8001, 32'hFFFF8001);
    check("lat1 outValid", {31'b0, outValid}, 32'h1);
    check("lat1 dataOut", dataOut, 32'hFFFF8001);
    send(2'b01, 16'hFFFE, 32'h0000FFFE);
    send(2'b10, 16'hFFFE, 32'hFFFE0000);
    send(2'b11, 16'hFFFE, 32'hFFFFFFF8);
    send(2'b00, 16'h7FFF, 32'h00007FFF);
    send(2'b11, 16'h4000, 32'h00010000);
    send(2'b10, 16'h1234, 32'h12340000);
    send(2'b01, 16'h8001, 32'h00008001);
    repeat (3) step();

    // Back-to-back stream with no bubbles.
    c0 = cyc;
    p0 = pops;
    for (int i = 0; i < 8; i++) send(s_mode[i], s_data[i], s_exp[i]);
    check("stream input cycles", c0 + 8, cyc);
    @(negedge clk);
    #1;
    check("stream outputs", pops - p0, 8);
    repeat (3) step();

    // Backpressure: only DEPTH requests fit.
    a0 = accepts;
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(b_mode[i], b_data[i], b_exp[i]);
      step();
    end
    inValid = 1'b0;
    check("bp accepted", accepts - a0, DEPTH);
    check("bp inReady", {31'b0, inReady}, 32'h0);
    check("bp outValid held", {31'b0, outValid}, 32'h1);
    check("bp dataOut held", dataOut, 32'h00001111);
    outReady = 1'b1;
    send(2'b00, 16'h0555, 32'h00000555);
    repeat (4) step();

    // Flush with a full stage and a pending request.
    outReady = 1'b0;
    drive(2'b00, 16'h5555, 32'h00005555);
    step();
    if (DEPTH > 1) begin
      drive(2'b00, 16'h6666, 32'h00006666);
      step();
    end
    drive(2'b00, 16'h7777, 32'h00007777);
    flush = 1'b1;
    #1;
    check("flush inReady", {31'b0, inReady}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    inValid = 1'b0;
    check("flush outValid", {31'b0, outValid}, 32'h0);
    check("flush dataOut", dataOut, 32'h0);
    outReady = 1'b1;
    send(2'b00, 16'h8888, 32'hFFFF8888);
    check("post flush dataOut", dataOut, 32'hFFFF8888);
    repeat (2) step();

    // Asynchronous reset while a result is held.
    outReady = 1'b0;
    send(2'b01, 16'h9999, 32'h00009999);
    check("pre reset outValid", {31'b0, outValid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset outValid", {31'b0, outValid}, 32'h0);
    check("async reset dataOut", dataOut, 32'h0);
    step();
    reset = 1'b0;
    outReady = 1'b1;
    repeat (2) step();
    check("no stale outValid", {31'b0, outValid}, 32'h0);
    check("post reset inReady", {31'b0, inReady}, 32'h1);
    send(2'b10, 16'h00AA, 32'h00AA0000);
    check("post reset dataOut", dataOut, 32'h00AA0000);
    repeat (3) step();
    check("scoreboard drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
